// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDRAM request/response link (initiator and responder).
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: bus widths, burst length, responder state encoding, burst address wrap helper.
package sdram_responder_pkg;

  localparam int SDRAM_AW    = 24;  // word address width on the link
  localparam int SDRAM_DW    = 16;  // data word width on the link
  localparam int BURST_LEN   = 8;   // words per read burst
  localparam int BURST_IDX_W = 3;   // log2(BURST_LEN)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WACK  = 2'd3
  } state_t;

  // Next word offset inside an aligned 8-word block (wraps 7 -> 0).
  function automatic logic [BURST_IDX_W-1:0] burst_wrap_inc(input logic [BURST_IDX_W-1:0] lo);
    return lo + 3'd1;
  endfunction

endpackage

// File: rtl/sdram_responder_spram.sv
// Single-port synchronous RAM, one byte lane of the responder backing store.
// Latency: 1 cycle registered read (read-before-write on the same address).
// Backpressure: none; always accepts a read and an optional write per cycle.
// Ports: clk, we (write enable), addr, wdata, rdata (registered read data).
module sdram_responder_spram #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// Simulated SDRAM responder: fixed-latency ack, 8-word wrapping read bursts, byte-masked writes.
// Latency: ack LATENCY cycles after the request is sampled; read words follow on the next 8 cycles.
// Backpressure: none; level requests are only sampled in IDLE and held by the initiator until ack.
// Ports: sys_clk, reset (sync, active-high), sdram_address/_data_write/_byte_mask,
//        sdram_read_req/_write_req in; sdram_data_read, sdram_read_ack/_write_ack out.
// Optional: define SDRAM_RESPONDER_STATS_EN to add stat_read_bursts / stat_write_words counters.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int MEM_AW  = 16,
  parameter int LATENCY = 3
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic [SDRAM_AW-1:0] sdram_address,
  input  logic [SDRAM_DW-1:0] sdram_data_write,
  input  logic [1:0]          sdram_byte_mask,
  input  logic                sdram_read_req,
  input  logic                sdram_write_req,
  output logic [SDRAM_DW-1:0] sdram_data_read,
  output logic                sdram_read_ack,
  output logic                sdram_write_ack
`ifdef SDRAM_RESPONDER_STATS_EN
  ,
  output logic [15:0]         stat_read_bursts,
  output logic [15:0]         stat_write_words
`endif
);

  state_t                 state;
  state_t                 state_nxt;

  logic [MEM_AW-1:0]      addr_q;
  logic [SDRAM_DW-1:0]    wdata_q;
  logic [1:0]             mask_q;
  logic                   is_wr_q;
  logic [3:0]             wait_cnt;
  logic [BURST_IDX_W-1:0] beat;
  logic [BURST_IDX_W-1:0] rd_lo;

  logic                   req_any;
  logic                   wait_last;
  logic                   beat_last;
  logic                   wr_commit;
  logic [MEM_AW-1:0]      mem_addr;
  logic [SDRAM_DW-1:0]    mem_rdata;

  // Address bits above the store are deliberately dropped so upper addresses alias.
  logic                   unused_addr_hi;
  assign unused_addr_hi = ^sdram_address[SDRAM_AW-1:MEM_AW];

  assign req_any   = sdram_read_req | sdram_write_req;
  assign wait_last = (wait_cnt == 4'd1);
  assign beat_last = (beat == 3'(BURST_LEN - 1));
  assign wr_commit = (state == ST_WACK) && is_wr_q;

  // The ack cycle is WACK for both directions; a read then moves on to its burst.
  assign sdram_write_ack = (state == ST_WACK) &&  is_wr_q;
  assign sdram_read_ack  = (state == ST_WACK) && !is_wr_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any)   state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_last) state_nxt = ST_WACK;
      ST_WACK:  state_nxt = is_wr_q ? ST_IDLE : ST_BURST;
      ST_BURST: if (beat_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // rd_lo runs one word ahead of the RAM output: it starts advancing in the
  // last WAIT cycle so word 0 is already in the RAM output register during the
  // ack cycle, and every burst cycle then captures a fresh word without bubbles.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sdram_data_read <= '0;
      wait_cnt        <= '0;
      beat            <= '0;
      rd_lo           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      mask_q          <= '0;
      is_wr_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            addr_q   <= sdram_address[MEM_AW-1:0];
            wdata_q  <= sdram_data_write;
            mask_q   <= sdram_byte_mask;
            is_wr_q  <= sdram_write_req;  // write wins when both are high
            wait_cnt <= 4'(LATENCY);
            rd_lo    <= sdram_address[BURST_IDX_W-1:0];
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_last) begin
            rd_lo <= burst_wrap_inc(rd_lo);
          end
        end
        ST_WACK: begin
          beat  <= '0;
          rd_lo <= burst_wrap_inc(rd_lo);
          if (!is_wr_q) begin
            sdram_data_read <= mem_rdata;
          end
        end
        ST_BURST: begin
          beat <= beat + 3'd1;
          // On the final beat the output simply holds the last word.
          if (!beat_last) begin
            sdram_data_read <= mem_rdata;
            rd_lo           <= burst_wrap_inc(rd_lo);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- backing store
  assign mem_addr = wr_commit ? addr_q : {addr_q[MEM_AW-1:BURST_IDX_W], rd_lo};

  sdram_responder_spram #(
    .AW (MEM_AW),
    .DW (8)
  ) u_mem_hi (
    .clk   (sys_clk),
    .we    (wr_commit && mask_q[1]),
    .addr  (mem_addr),
    .wdata (wdata_q[15:8]),
    .rdata (mem_rdata[15:8])
  );

  sdram_responder_spram #(
    .AW (MEM_AW),
    .DW (8)
  ) u_mem_lo (
    .clk   (sys_clk),
    .we    (wr_commit && mask_q[0]),
    .addr  (mem_addr),
    .wdata (wdata_q[7:0]),
    .rdata (mem_rdata[7:0])
  );

`ifdef SDRAM_RESPONDER_STATS_EN
  // ---------------------------------------------------------------- statistics
  logic [15:0] stat_read_q;
  logic [15:0] stat_write_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      stat_read_q  <= '0;
      stat_write_q <= '0;
    end else begin
      if (sdram_read_ack && (stat_read_q != 16'hFFFF)) begin
        stat_read_q <= stat_read_q + 16'd1;
      end
      if (sdram_write_ack && (stat_write_q != 16'hFFFF)) begin
        stat_write_q <= stat_write_q + 16'd1;
      end
    end
  end

  assign stat_read_bursts = stat_read_q;
  assign stat_write_words = stat_write_q;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed testbench for sdram_responder (MEM_AW=16, LATENCY=3).
// Inputs are driven 1 time unit after the rising edge and outputs sampled there too.
// Define SDRAM_RESPONDER_STATS_EN to also exercise the statistics counters.
module tb_sdram_responder;
  import sdram_responder_pkg::*;

  localparam int LAT = 3;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [23:0] sdram_address;
  logic [15:0] sdram_data_write;
  logic [1:0]  sdram_byte_mask;
  logic        sdram_read_req;
  logic        sdram_write_req;
  logic [15:0] sdram_data_read;
  logic        sdram_read_ack;
  logic        sdram_write_ack;
`ifdef SDRAM_RESPONDER_STATS_EN
  logic [15:0] stat_read_bursts;
  logic [15:0] stat_write_words;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] rd_words [8];

  always #5 sys_clk = ~sys_clk;

  sdram_responder #(
    .MEM_AW  (16),
    .LATENCY (LAT)
  ) dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .sdram_address    (sdram_address),
    .sdram_data_write (sdram_data_write),
    .sdram_byte_mask  (sdram_byte_mask),
    .sdram_read_req   (sdram_read_req),
    .sdram_write_req  (sdram_write_req),
    .sdram_data_read  (sdram_data_read),
    .sdram_read_ack   (sdram_read_ack),
    .sdram_write_ack  (sdram_write_ack)
`ifdef SDRAM_RESPONDER_STATS_EN
    ,
    .stat_read_bursts (stat_read_bursts),
    .stat_write_words (stat_write_words)
`endif
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue a write from IDLE, measure ack latency, return in IDLE.
  task automatic do_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] m,
                          input string name);
    int lat;
    sdram_address    = a;
    sdram_data_write = d;
    sdram_byte_mask  = m;
    sdram_write_req  = 1'b1;
    tick();
    lat = 0;
    while (sdram_write_ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    sdram_write_req = 1'b0;
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL %s write_ack latency: got %0d cycles, expected %0d", name, lat, LAT);
    end
    tick();
    vectors++;
    if (sdram_write_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL %s write_ack pulse width: got %b after ack cycle, expected 0", name, sdram_write_ack);
    end
  endtask

  // Issue a read from IDLE, measure ack latency, capture 8 burst words, return in IDLE.
  task automatic do_read(input logic [23:0] a, input string name);
    int lat;
    sdram_address  = a;
    sdram_read_req = 1'b1;
    tick();
    lat = 0;
    while (sdram_read_ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    sdram_read_req = 1'b0;
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL %s read_ack latency: got %0d cycles, expected %0d", name, lat, LAT);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_words[k] = sdram_data_read;
    end
    tick();
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    sdram_read_req  = 1'b0;
    sdram_write_req = 1'b0;
    tick();
    tick();
    vectors++;
    if (sdram_read_ack !== 1'b0 || sdram_write_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_acks: got rd=%b wr=%b, expected 0 0", sdram_read_ack, sdram_write_ack);
    end
    vectors++;
    if (sdram_data_read !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 0000", sdram_data_read);
    end
    vectors++;
    if (dut.state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, expected IDLE", dut.state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(24'h000010, 16'hBEEF, 2'b11, "wr_beef");
    do_read(24'h000010, "rd_beef");
    vectors++;
    if (rd_words[0] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL rd_beef word0: got %h, expected BEEF", rd_words[0]);
    end
  endtask

  task automatic test_burst_wrap();
    logic [15:0] exp_words [8];
    exp_words = '{16'h1005, 16'h1006, 16'h1007, 16'h1000,
                  16'h1001, 16'h1002, 16'h1003, 16'h1004};
    for (int i = 0; i < 8; i++) begin
      do_write(24'h000020 + 24'(i), 16'h1000 + 16'(i), 2'b11, "preload");
    end
    do_read(24'h000025, "rd_wrap");
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (rd_words[k] !== exp_words[k]) begin
        miscompares++;
        $display("FAIL rd_wrap word%0d: got %h, expected %h", k, rd_words[k], exp_words[k]);
      end
    end
    vectors++;
    if (sdram_data_read !== 16'h1004) begin
      miscompares++;
      $display("FAIL rd_wrap hold: got %h, expected 1004", sdram_data_read);
    end
  endtask

  task automatic test_byte_mask();
    do_write(24'h000030, 16'h1234, 2'b11, "mask_init");
    do_write(24'h000030, 16'hABCD, 2'b10, "mask_10");
    do_read(24'h000030, "rd_mask_10");
    vectors++;
    if (rd_words[0] !== 16'hAB34) begin
      miscompares++;
      $display("FAIL mask_10 data: got %h, expected AB34", rd_words[0]);
    end
    do_write(24'h000030, 16'h1234, 2'b11, "mask_reinit");
    do_write(24'h000030, 16'hABCD, 2'b00, "mask_00");
    do_read(24'h000030, "rd_mask_00");
    vectors++;
    if (rd_words[0] !== 16'h1234) begin
      miscompares++;
      $display("FAIL mask_00 data: got %h, expected 1234", rd_words[0]);
    end
    do_write(24'h000030, 16'hABCD, 2'b01, "mask_01");
    do_read(24'h000030, "rd_mask_01");
    vectors++;
    if (rd_words[0] !== 16'h12CD) begin
      miscompares++;
      $display("FAIL mask_01 data: got %h, expected 12CD", rd_words[0]);
    end
  endtask

  task automatic test_alias();
    do_write(24'h010040, 16'h5A5A, 2'b11, "alias_wr");
    do_write(24'hFF0041, 16'hC3C3, 2'b11, "alias_wr2");
    do_read(24'h000040, "alias_rd");
    vectors++;
    if (rd_words[0] !== 16'h5A5A || rd_words[1] !== 16'hC3C3) begin
      miscompares++;
      $display("FAIL alias data: got %h %h, expected 5A5A C3C3", rd_words[0], rd_words[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    bit rd_early;
    sdram_address    = 24'h000050;
    sdram_data_write = 16'h7777;
    sdram_byte_mask  = 2'b11;
    sdram_write_req  = 1'b1;
    sdram_read_req   = 1'b1;
    tick();
    lat      = 0;
    rd_early = 1'b0;
    while (sdram_write_ack !== 1'b1 && lat < 40) begin
      if (sdram_read_ack === 1'b1) rd_early = 1'b1;
      tick();
      lat++;
    end
    sdram_write_req = 1'b0;
    vectors++;
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL collide write_ack latency: got %0d, expected %0d", lat, LAT);
    end
    vectors++;
    if (rd_early || sdram_read_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL collide read_ack early: got 1, expected 0 before write ack completes");
    end
    // Ack cycle -> IDLE cycle -> sampling edge -> LAT WAIT cycles -> read ack.
    n = 0;
    do begin
      tick();
      n++;
    end while (sdram_read_ack !== 1'b1 && n < 40);
    sdram_read_req = 1'b0;
    vectors++;
    if (n != LAT + 2) begin
      miscompares++;
      $display("FAIL collide read_ack delay: got %0d cycles after write ack, expected %0d", n, LAT + 2);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      rd_words[k] = sdram_data_read;
    end
    tick();
    vectors++;
    if (rd_words[0] !== 16'h7777) begin
      miscompares++;
      $display("FAIL collide read data: got %h, expected 7777", rd_words[0]);
    end
  endtask

  task automatic test_reset_midburst();
    int lat;
    sdram_address  = 24'h000020;
    sdram_read_req = 1'b1;
    tick();
    lat = 0;
    while (sdram_read_ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    sdram_read_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vectors++;
    if (sdram_data_read !== 16'h1003) begin
      miscompares++;
      $display("FAIL midburst word3: got %h, expected 1003", sdram_data_read);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (sdram_read_ack !== 1'b0 || sdram_write_ack !== 1'b0 || sdram_data_read !== 16'h0000) begin
      miscompares++;
      $display("FAIL midburst reset outputs: got rd=%b wr=%b data=%h, expected 0 0 0000",
               sdram_read_ack, sdram_write_ack, sdram_data_read);
    end
    vectors++;
    if (dut.state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL midburst reset state: got %0d, expected IDLE", dut.state);
    end
    tick();
    do_read(24'h000022, "rd_after_reset");
    vectors++;
    if (rd_words[0] !== 16'h1002 || rd_words[7] !== 16'h1001) begin
      miscompares++;
      $display("FAIL after_reset data: got %h..%h, expected 1002..1001", rd_words[0], rd_words[7]);
    end
  endtask

`ifdef SDRAM_RESPONDER_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) do_read(24'h000020, "stat_rd");
    for (int i = 0; i < 5; i++) do_write(24'h000060 + 24'(i), 16'h0100 + 16'(i), 2'b11, "stat_wr");
    vectors++;
    if (stat_read_bursts !== 16'd3 || stat_write_words !== 16'd5) begin
      miscompares++;
      $display("FAIL stats counts: got rd=%0d wr=%0d, expected 3 5", stat_read_bursts, stat_write_words);
    end
    force dut.stat_read_q = 16'hFFFF;
    tick();
    release dut.stat_read_q;
    do_read(24'h000020, "stat_sat");
    vectors++;
    if (stat_read_bursts !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats saturate: got %h, expected FFFF", stat_read_bursts);
    end
  endtask
`endif

  initial begin
    reset            = 1'b1;
    sdram_address    = '0;
    sdram_data_write = '0;
    sdram_byte_mask  = 2'b00;
    sdram_read_req   = 1'b0;
    sdram_write_req  = 1'b0;
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_byte_mask();
    test_alias();
    test_back_to_back();
    test_reset_midburst();
`ifdef SDRAM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
